// File: rtl/bitstream_pkg.sv
// Shared types and constants for the bitstream window.
// Stream states, default geometry and the byte-align helper.
package bitstream_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        RUN,
        DRAIN,
        DONE
    } state_e;

    localparam int DEF_IN_W      = 16;
    localparam int DEF_WIN_W     = 16;
    localparam int DEF_MAX_SHIFT = 16;
    localparam int DEF_BUF_W     = 64;
    localparam int DEF_CNT_W     = 32;

    // Bits to the next byte boundary: (8 - bitcnt) mod 8.
    function automatic logic [2:0] align_amount(input logic [2:0] bitcnt);
        return 3'(4'd8 - {1'b0, bitcnt});
    endfunction

endpackage

// File: rtl/bitstream_window_bitbuf_core.sv
// MSB-first bit buffer; valid bits are left-aligned and
// everything below Level is kept at zero.
module bitbuf_core #(
    parameter int IN_W  = 16,
    parameter int WIN_W = 16,
    parameter int BUF_W = 64,
    parameter int LW    = $clog2(BUF_W + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    input  logic             push_i,
    input  logic [IN_W-1:0]  push_data_i,
    input  logic             pop_i,
    input  logic [LW-1:0]    pop_amt_i,
    output logic [WIN_W-1:0] window_o,
    output logic [LW-1:0]    level_o,
    output logic [LW-1:0]    level_nx_o
);

    logic [BUF_W-1:0] bits_q, bits_d, kept;
    logic [LW-1:0]    level_q, level_d, kept_lv;

    always_comb begin
        kept    = pop_i ? (bits_q << pop_amt_i) : bits_q;
        kept_lv = pop_i ? (level_q - pop_amt_i) : level_q;
        bits_d  = kept;
        level_d = kept_lv;
        // New word lands right after the bits that survive the pop.
        if (push_i) begin
            bits_d  = kept | ({push_data_i, {(BUF_W-IN_W){1'b0}}} >> kept_lv);
            level_d = kept_lv + LW'(IN_W);
        end
        if (clr_i) begin
            bits_d  = '0;
            level_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bits_q  <= '0;
            level_q <= '0;
        end else begin
            bits_q  <= bits_d;
            level_q <= level_d;
        end
    end

    assign window_o   = bits_q[BUF_W-1 -: WIN_W];
    assign level_o    = level_q;
    assign level_nx_o = level_d;

endmodule

// File: rtl/bitstream_window.sv
// Bitstream peek window with variable consume, byte align,
// end-of-stream drain, bit counter and sticky error flag.
module bitstream_window
    import bitstream_pkg::*;
#(
    parameter int IN_W      = DEF_IN_W,
    parameter int WIN_W     = DEF_WIN_W,
    parameter int MAX_SHIFT = DEF_MAX_SHIFT,
    parameter int BUF_W     = DEF_BUF_W,
    parameter int CNT_W     = DEF_CNT_W
) (
    input  logic                           Clk,
    input  logic                           nReset,
    input  logic                           Enable,
    input  logic [IN_W-1:0]                InData,
    input  logic                           InValid,
    input  logic                           InLast,
    output logic                           InReady,
    input  logic                           ShiftEn,
    input  logic [$clog2(MAX_SHIFT+1)-1:0] NumShift,
    input  logic                           AlignEn,
    output logic [WIN_W-1:0]               Window,
    output logic                           WinValid,
    output logic [$clog2(BUF_W+1)-1:0]     Level,
    output logic [CNT_W-1:0]               BitCount,
    output logic                           ShiftErr,
    output logic                           Done
);

    localparam int LW = $clog2(BUF_W + 1);
    localparam int SW = $clog2(MAX_SHIFT + 1);

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             err_q;
    logic [LW-1:0]    level, level_nx, amt;
    logic             win_valid, ready, accept, req, bad, take;

    assign ready = Enable
                && (state_q == FILL || state_q == RUN)
                && (({1'b0, level} + (LW+1)'(IN_W)) <= (LW+1)'(BUF_W));

    assign win_valid = (state_q == RUN && level >= LW'(WIN_W))
                    || (state_q == DRAIN && level != '0);

    assign req    = ShiftEn | AlignEn;
    assign amt    = AlignEn ? LW'(align_amount(cnt_q[2:0])) : LW'(NumShift);
    assign bad    = !win_valid
                 || (ShiftEn && AlignEn)
                 || (ShiftEn && NumShift > SW'(MAX_SHIFT))
                 || (state_q == DRAIN && amt > level);
    assign take   = Enable && req && !bad;
    assign accept = InValid && ready;

    bitbuf_core #(
        .IN_W  (IN_W),
        .WIN_W (WIN_W),
        .BUF_W (BUF_W),
        .LW    (LW)
    ) u_core (
        .clk         (Clk),
        .rst_n       (nReset),
        .clr_i       (!Enable),
        .push_i      (accept),
        .push_data_i (InData),
        .pop_i       (take),
        .pop_amt_i   (amt),
        .window_o    (Window),
        .level_o     (level),
        .level_nx_o  (level_nx)
    );

    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else if (!Enable) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            if (req && bad) err_q <= 1'b1;
            if (take)       cnt_q <= cnt_q + CNT_W'(amt);
            unique case (state_q)
                IDLE: state_q <= FILL;
                FILL, RUN: begin
                    if (accept && InLast)
                        state_q <= DRAIN;
                    else if (level_nx >= LW'(WIN_W))
                        state_q <= RUN;
                    else
                        state_q <= FILL;
                end
                DRAIN: if (level_nx == '0) state_q <= DONE;
                DONE:  state_q <= DONE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign InReady  = ready;
    assign WinValid = win_valid;
    assign Level    = level;
    assign BitCount = cnt_q;
    assign ShiftErr = err_q;
    assign Done     = (state_q == DONE);

endmodule

// File: tb/tb_bitstream_window.sv
// Directed bench for bitstream_window with a bit-queue
// reference model and a scoreboard of post-edge expectations.
module tb_bitstream_window;

    localparam int S_IDLE  = 0;
    localparam int S_FILL  = 1;
    localparam int S_RUN   = 2;
    localparam int S_DRAIN = 3;
    localparam int S_DONE  = 4;

    logic        Clk = 1'b0;
    logic        nReset, Enable, InValid, InLast, ShiftEn, AlignEn;
    logic [15:0] InData;
    logic [4:0]  NumShift;
    logic        InReady, WinValid, ShiftErr, Done;
    logic [15:0] Window;
    logic [6:0]  Level;
    logic [31:0] BitCount;

    bitstream_window dut (
        .Clk      (Clk),
        .nReset   (nReset),
        .Enable   (Enable),
        .InData   (InData),
        .InValid  (InValid),
        .InLast   (InLast),
        .InReady  (InReady),
        .ShiftEn  (ShiftEn),
        .NumShift (NumShift),
        .AlignEn  (AlignEn),
        .Window   (Window),
        .WinValid (WinValid),
        .Level    (Level),
        .BitCount (BitCount),
        .ShiftErr (ShiftErr),
        .Done     (Done)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [15:0] win;
        int          lvl;
        int          cnt;
        logic        err;
        logic        wv;
        logic        done;
    } exp_t;

    exp_t  sbq[$];
    string tagq[$];
    bit    mdl[$];
    int    ms;
    int    mcnt;
    logic  merr;
    int    n_assert = 0;
    int    n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] model_win();
        logic [15:0] w;
        w = '0;
        for (int i = 0; i < 16; i++)
            if (i < mdl.size()) w[15-i] = mdl[i];
        return w;
    endfunction

    function automatic logic model_wv();
        return (ms == S_RUN && mdl.size() >= 16)
            || (ms == S_DRAIN && mdl.size() > 0);
    endfunction

    task automatic cyc(input string tag, input logic en, input logic v,
                       input logic [15:0] d, input logic last,
                       input logic sh, input int n, input logic al);
        logic rdy, req, bad, acc;
        int   amt;
        exp_t e;
        string t;
        Enable   = en;
        InValid  = v;
        InData   = d;
        InLast   = last;
        ShiftEn  = sh;
        NumShift = 5'(n);
        AlignEn  = al;
        rdy = en && (ms == S_FILL || ms == S_RUN) && (mdl.size() + 16 <= 64);
        #1;
        chk({tag, ".ready"}, 64'(InReady), 64'(rdy));
        acc = v && rdy;
        req = sh || al;
        amt = al ? ((8 - (mcnt % 8)) % 8) : n;
        bad = !model_wv() || (sh && al) || (sh && n > 16)
           || (ms == S_DRAIN && amt > mdl.size());
        if (!en) begin
            mdl.delete();
            mcnt = 0;
            merr = 1'b0;
            ms   = S_IDLE;
        end else begin
            if (req && bad) merr = 1'b1;
            if (req && !bad) begin
                for (int i = 0; i < amt; i++) void'(mdl.pop_front());
                mcnt += amt;
            end
            if (acc)
                for (int i = 15; i >= 0; i--) mdl.push_back(d[i]);
            case (ms)
                S_IDLE: ms = S_FILL;
                S_FILL, S_RUN:
                    if (acc && last) ms = S_DRAIN;
                    else ms = (mdl.size() >= 16) ? S_RUN : S_FILL;
                S_DRAIN: if (mdl.size() == 0) ms = S_DONE;
                default: ;
            endcase
        end
        e.win  = model_win();
        e.lvl  = mdl.size();
        e.cnt  = mcnt;
        e.err  = merr;
        e.wv   = model_wv();
        e.done = (ms == S_DONE);
        sbq.push_back(e);
        tagq.push_back(tag);
        @(posedge Clk);
        #1;
        e = sbq.pop_front();
        t = tagq.pop_front();
        chk({t, ".window"},   64'(Window),   64'(e.win));
        chk({t, ".level"},    64'(Level),    64'(e.lvl));
        chk({t, ".bitcount"}, 64'(BitCount), 64'(e.cnt));
        chk({t, ".shifterr"}, 64'(ShiftErr), 64'(e.err));
        chk({t, ".winvalid"}, 64'(WinValid), 64'(e.wv));
        chk({t, ".done"},     64'(Done),     64'(e.done));
    endtask

    initial begin
        ms = S_IDLE; mcnt = 0; merr = 1'b0;
        nReset = 1'b0; Enable = 1'b0; InValid = 1'b0; InLast = 1'b0;
        ShiftEn = 1'b0; AlignEn = 1'b0; InData = '0; NumShift = '0;
        #12;
        chk("rst.window",   64'(Window),   64'h0);
        chk("rst.level",    64'(Level),    64'h0);
        chk("rst.bitcount", 64'(BitCount), 64'h0);
        chk("rst.shifterr", 64'(ShiftErr), 64'h0);
        chk("rst.winvalid", 64'(WinValid), 64'h0);
        chk("rst.inready",  64'(InReady),  64'h0);
        chk("rst.done",     64'(Done),     64'h0);
        nReset = 1'b1;

        // tag, en, valid, data, last, shift, n, align
        cyc("enable",  1, 0, 16'h0000, 0, 0,  0, 0);
        cyc("fill0",   1, 1, 16'hA5A5, 0, 0,  0, 0);
        cyc("fill1",   1, 1, 16'h3C3C, 0, 0,  0, 0);
        cyc("str3",    1, 1, 16'h1234, 0, 1,  3, 0);
        cyc("str13",   1, 1, 16'h5678, 0, 1, 13, 0);
        cyc("str16",   1, 1, 16'h9ABC, 0, 1, 16, 0);
        cyc("str5",    1, 1, 16'hDEF0, 0, 1,  5, 0);
        cyc("zero",    1, 0, 16'h0000, 0, 1,  0, 0);
        cyc("full",    1, 1, 16'h1111, 0, 0,  0, 0);
        cyc("to48",    1, 0, 16'h0000, 0, 1, 11, 0);
        cyc("bp48",    1, 1, 16'h2222, 0, 1, 16, 0);
        cyc("to64",    1, 1, 16'h3333, 0, 0,  0, 0);
        cyc("stall64", 1, 1, 16'h4444, 0, 0,  0, 0);
        cyc("sh13",    1, 0, 16'h0000, 0, 1, 13, 0);
        cyc("align3",  1, 0, 16'h0000, 0, 0,  0, 1);
        cyc("align0",  1, 0, 16'h0000, 0, 0,  0, 1);
        cyc("err17",   1, 0, 16'h0000, 0, 1, 17, 0);
        cyc("errboth", 1, 0, 16'h0000, 0, 1,  4, 1);
        cyc("flush",   0, 1, 16'h5555, 0, 1,  4, 0);
        cyc("re_en",   1, 0, 16'h0000, 0, 0,  0, 0);
        cyc("sfill",   1, 1, 16'hBEEF, 0, 0,  0, 0);
        cyc("starve",  1, 0, 16'h0000, 0, 1,  8, 0);
        cyc("errfill", 1, 0, 16'h0000, 0, 1,  1, 0);
        cyc("flush2",  0, 0, 16'h0000, 0, 0,  0, 0);
        cyc("re_en2",  1, 0, 16'h0000, 0, 0,  0, 0);
        cyc("last",    1, 1, 16'hF000, 1, 0,  0, 0);
        cyc("drain4",  1, 0, 16'h0000, 0, 1,  4, 0);
        cyc("drain13", 1, 0, 16'h0000, 0, 1, 13, 0);
        cyc("drain12", 1, 0, 16'h0000, 0, 1, 12, 0);
        cyc("donehld", 1, 1, 16'h6666, 0, 0,  0, 0);
        cyc("flush3",  0, 0, 16'h0000, 0, 0,  0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
